// File: rtl/data_mem_lsu_if.sv
// rtl/data_mem_lsu_if.sv - request/response bus between the LSU stage and the data memory
interface data_mem_lsu_if #(
   parameter int ADDR_WIDTH = 12
);
   logic                  req_valid;
   logic                  req_ready;
   logic                  req_we;
   logic [1:0]            req_size;
   logic                  req_unsigned;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic [31:0]           req_wdata;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [31:0]           rsp_rdata;
   logic                  rsp_fault;

   // LSU side: issues requests, consumes responses
   modport master (
      output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_fault
   );

   // memory side: accepts requests, produces responses
   modport slave (
      input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_fault
   );
endinterface

// File: rtl/data_mem_lsu.sv
// rtl/data_mem_lsu.sv - byte-addressed RV32 data memory with B/H/W sizing, faulting and wait states
module data_mem_lsu #(
   parameter int ADDR_WIDTH  = 12,
   parameter int WAIT_CYCLES = 0,
   parameter     INIT_FILE   = ""
) (
   input  logic          clk,
   input  logic          rst_n,
   data_mem_lsu_if.slave bus
);
   localparam int         DEPTH     = 2 ** (ADDR_WIDTH - 2);
   localparam bit         NO_WAIT   = (WAIT_CYCLES == 0);
   localparam logic [3:0] WAIT_LOAD = NO_WAIT ? 4'd0 : 4'(WAIT_CYCLES - 1);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t state, state_n;

   logic [31:0]           mem [DEPTH];
   logic [3:0]            wait_cnt;
   logic [31:0]           pend_rdata;
   logic                  pend_fault;
   logic [31:0]           rsp_rdata_q;
   logic                  rsp_fault_q;

   logic                  accept;
   logic                  fault_c;
   logic [1:0]            lane;
   logic [ADDR_WIDTH-3:0] idx;
   logic [3:0]            be;
   logic [31:0]           wdata_lanes;
   logic [31:0]           rd_word;
   logic [7:0]            rd_byte;
   logic [15:0]           rd_half;
   logic [31:0]           ld_c;
   logic [31:0]           result_c;

   assign lane          = bus.req_addr[1:0];
   assign idx           = bus.req_addr[ADDR_WIDTH-1:2];
   assign bus.req_ready = (state == S_IDLE);
   assign accept        = bus.req_valid & bus.req_ready;
   assign bus.rsp_valid = (state == S_RESP);
   assign bus.rsp_rdata = rsp_rdata_q;
   assign bus.rsp_fault = rsp_fault_q;
   assign rd_word       = mem[idx];

   // misaligned halves/words and the reserved size code all fault
   always_comb begin
      fault_c = 1'b0;
      case (bus.req_size)
         2'd1:    fault_c = lane[0];
         2'd2:    fault_c = (lane != 2'b00);
         2'd3:    fault_c = 1'b1;
         default: fault_c = 1'b0;
      endcase
   end

   // replicate right-aligned store data across lanes and pick the byte enables
   always_comb begin
      be          = 4'b0000;
      wdata_lanes = bus.req_wdata;
      case (bus.req_size)
         2'd0: begin
            be          = 4'b0001 << lane;
            wdata_lanes = {4{bus.req_wdata[7:0]}};
         end
         2'd1: begin
            be          = lane[1] ? 4'b1100 : 4'b0011;
            wdata_lanes = {2{bus.req_wdata[15:0]}};
         end
         2'd2: be = 4'b1111;
         default: be = 4'b0000;
      endcase
   end

   // extract the addressed byte/half/word and extend; stores and faults return zero
   always_comb begin
      rd_byte = 8'h00;
      rd_half = lane[1] ? rd_word[31:16] : rd_word[15:0];
      ld_c    = 32'h0;
      case (lane)
         2'd0: rd_byte = rd_word[7:0];
         2'd1: rd_byte = rd_word[15:8];
         2'd2: rd_byte = rd_word[23:16];
         default: rd_byte = rd_word[31:24];
      endcase
      case (bus.req_size)
         2'd0: ld_c = bus.req_unsigned ? {24'h0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
         2'd1: ld_c = bus.req_unsigned ? {16'h0, rd_half} : {{16{rd_half[15]}}, rd_half};
         2'd2: ld_c = rd_word;
         default: ld_c = 32'h0;
      endcase
      result_c = (fault_c || bus.req_we) ? 32'h0 : ld_c;
   end

   // commit stores on the accept edge; contents survive reset
   always_ff @(posedge clk) begin
      if (rst_n && accept && bus.req_we && !fault_c) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) mem[idx][8*i +: 8] <= wdata_lanes[8*i +: 8];
         end
      end
   end

   // state register
   always_ff @(posedge clk) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_n;
   end

   // next-state: skip WAIT entirely when no wait states are configured
   always_comb begin
      state_n = state;
      case (state)
         S_IDLE: if (accept) state_n = NO_WAIT ? S_RESP : S_WAIT;
         S_WAIT: if (wait_cnt == 4'd0) state_n = S_RESP;
         S_RESP: if (bus.rsp_ready) state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
   end

   // wait counter plus response staging; outputs only change when entering RESP
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wait_cnt    <= 4'd0;
         pend_rdata  <= 32'h0;
         pend_fault  <= 1'b0;
         rsp_rdata_q <= 32'h0;
         rsp_fault_q <= 1'b0;
      end else if (state == S_IDLE && accept) begin
         wait_cnt   <= WAIT_LOAD;
         pend_rdata <= result_c;
         pend_fault <= fault_c;
         if (NO_WAIT) begin
            rsp_rdata_q <= result_c;
            rsp_fault_q <= fault_c;
         end
      end else if (state == S_WAIT) begin
         if (wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
         end else begin
            rsp_rdata_q <= pend_rdata;
            rsp_fault_q <= pend_fault;
         end
      end
   end
endmodule

// File: tb/tb_data_mem_lsu.sv
// tb/tb_data_mem_lsu.sv - scoreboard bench for data_mem_lsu with two wait states
module tb_data_mem_lsu;
   logic clk = 1'b0;
   logic rst_n = 1'b0;

   typedef struct {
      logic [31:0] rdata;
      logic        fault;
   } exp_t;

   exp_t exp_q[$];
   int   n_vec = 0;
   int   n_err = 0;

   data_mem_lsu_if #(.ADDR_WIDTH(12)) dif ();

   data_mem_lsu #(
      .ADDR_WIDTH (12),
      .WAIT_CYCLES(2),
      .INIT_FILE  ("")
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (dif.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // monitor: every accepted response is popped and compared against the scoreboard
   always @(negedge clk) begin
      if (rst_n && dif.rsp_valid && dif.rsp_ready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_rsp", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("rsp_rdata", dif.rsp_rdata, e.rdata);
            chk("rsp_fault", {31'b0, dif.rsp_fault}, {31'b0, e.fault});
         end
      end
   end

   task automatic drive(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [11:0] a, input logic [31:0] wd);
      dif.req_we       = we;
      dif.req_size     = sz;
      dif.req_unsigned = uns;
      dif.req_addr     = a;
      dif.req_wdata    = wd;
      dif.req_valid    = 1'b1;
   endtask

   task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [11:0] a, input logic [31:0] wd,
                        input logic [31:0] er, input logic ef);
      int guard;
      exp_q.push_back('{rdata: er, fault: ef});
      @(negedge clk);
      drive(we, sz, uns, a, wd);
      guard = 0;
      while (!dif.req_ready && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      if (!dif.req_ready) chk("ready_timeout", {31'b0, dif.req_ready}, 32'd1);
      @(posedge clk);
      #1 dif.req_valid = 1'b0;
      guard = 0;
      while (exp_q.size() != 0 && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      chk("rsp_drain", exp_q.size(), 32'd0);
      if (exp_q.size() != 0) exp_q.delete();
   endtask

   initial begin
      dif.req_valid    = 1'b0;
      dif.req_we       = 1'b0;
      dif.req_size     = 2'd0;
      dif.req_unsigned = 1'b0;
      dif.req_addr     = '0;
      dif.req_wdata    = '0;
      dif.rsp_ready    = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("rst_req_ready", {31'b0, dif.req_ready}, 32'd1);
      chk("rst_rsp_valid", {31'b0, dif.rsp_valid}, 32'd0);
      chk("rst_rsp_rdata", dif.rsp_rdata, 32'd0);
      chk("rst_rsp_fault", {31'b0, dif.rsp_fault}, 32'd0);

      // word store then load back
      issue(1'b1, 2'd2, 1'b0, 12'h010, 32'hDEADBEEF, 32'h0, 1'b0);
      issue(1'b0, 2'd2, 1'b0, 12'h010, 32'h0, 32'hDEADBEEF, 1'b0);
      // sub-word loads with sign/zero extension
      issue(1'b0, 2'd0, 1'b0, 12'h013, 32'h0, 32'hFFFFFFDE, 1'b0);
      issue(1'b0, 2'd0, 1'b1, 12'h013, 32'h0, 32'h000000DE, 1'b0);
      issue(1'b0, 2'd1, 1'b0, 12'h012, 32'h0, 32'hFFFFDEAD, 1'b0);
      issue(1'b0, 2'd1, 1'b1, 12'h010, 32'h0, 32'h0000BEEF, 1'b0);
      issue(1'b0, 2'd2, 1'b1, 12'h010, 32'h0, 32'hDEADBEEF, 1'b0);
      // byte and half stores into lanes 1 and 2-3
      issue(1'b1, 2'd0, 1'b0, 12'h011, 32'hFFFFFF55, 32'h0, 1'b0);
      issue(1'b1, 2'd1, 1'b0, 12'h012, 32'hABCD1234, 32'h0, 1'b0);
      issue(1'b0, 2'd2, 1'b0, 12'h010, 32'h0, 32'h123455EF, 1'b0);
      issue(1'b0, 2'd1, 1'b0, 12'h012, 32'h0, 32'h00001234, 1'b0);
      issue(1'b0, 2'd0, 1'b0, 12'h011, 32'h0, 32'h00000055, 1'b0);
      // faults: misaligned word/half and illegal size, no write
      issue(1'b0, 2'd2, 1'b0, 12'h012, 32'h0, 32'h0, 1'b1);
      issue(1'b1, 2'd1, 1'b0, 12'h011, 32'h0000FFFF, 32'h0, 1'b1);
      issue(1'b1, 2'd3, 1'b0, 12'h010, 32'h00000000, 32'h0, 1'b1);
      issue(1'b1, 2'd2, 1'b0, 12'h011, 32'hFFFFFFFF, 32'h0, 1'b1);
      issue(1'b0, 2'd2, 1'b0, 12'h010, 32'h0, 32'h123455EF, 1'b0);

      // latency and backpressure: response three cycles after accept, held while not ready
      exp_q.push_back('{rdata: 32'h123455EF, fault: 1'b0});
      @(negedge clk);
      dif.rsp_ready = 1'b0;
      drive(1'b0, 2'd2, 1'b0, 12'h010, 32'h0);
      chk("lat_ready_idle", {31'b0, dif.req_ready}, 32'd1);
      @(posedge clk);
      #1 dif.req_valid = 1'b0;
      @(negedge clk);
      chk("lat_c1_valid", {31'b0, dif.rsp_valid}, 32'd0);
      @(negedge clk);
      chk("lat_c2_valid", {31'b0, dif.rsp_valid}, 32'd0);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk("hold_valid", {31'b0, dif.rsp_valid}, 32'd1);
         chk("hold_rdata", dif.rsp_rdata, 32'h123455EF);
         chk("hold_ready", {31'b0, dif.req_ready}, 32'd0);
      end
      @(posedge clk);
      #1 dif.rsp_ready = 1'b1;
      @(negedge clk);
      @(posedge clk);
      @(negedge clk);
      chk("post_hs_ready", {31'b0, dif.req_ready}, 32'd1);
      chk("post_hs_valid", {31'b0, dif.rsp_valid}, 32'd0);
      chk("post_hs_drain", exp_q.size(), 32'd0);

      // reset during WAIT of a store: response dropped, store kept
      @(negedge clk);
      drive(1'b1, 2'd2, 1'b0, 12'h020, 32'hA5A5A5A5);
      @(posedge clk);
      #1 dif.req_valid = 1'b0;
      @(negedge clk);
      chk("wait_ready", {31'b0, dif.req_ready}, 32'd0);
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("mid_rst_ready", {31'b0, dif.req_ready}, 32'd1);
      chk("mid_rst_valid", {31'b0, dif.rsp_valid}, 32'd0);
      chk("mid_rst_rdata", dif.rsp_rdata, 32'd0);
      chk("mid_rst_fault", {31'b0, dif.rsp_fault}, 32'd0);
      rst_n = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk("no_rsp_after_rst", {31'b0, dif.rsp_valid}, 32'd0);
      end
      issue(1'b0, 2'd2, 1'b0, 12'h020, 32'h0, 32'hA5A5A5A5, 1'b0);
      issue(1'b0, 2'd0, 1'b1, 12'h022, 32'h0, 32'h000000A5, 1'b0);

      repeat (2) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
